// File: rtl/video_rx_pkg.sv
// Shared state encoding, default widths and timing-record layout for the
// video timing receiver.
package video_rx_pkg;

  typedef enum logic [1:0] {IDLE, ARMED, RUN} rx_state_t;

  localparam int DEF_CNT_BITS    = 12;
  localparam int DEF_SUM_BITS    = 32;
  localparam int DEF_LOCK_FRAMES = 2;

  // Timing record: six CNT_BITS fields, packed as [NUM_TIMING-1:0][CNT_BITS-1:0].
  localparam int NUM_TIMING = 6;
  localparam int T_HTOTAL   = 0;
  localparam int T_HACTIVE  = 1;
  localparam int T_HSYNC    = 2;
  localparam int T_VTOTAL   = 3;
  localparam int T_VACTIVE  = 4;
  localparam int T_VSYNC    = 5;

endpackage

// File: rtl/video_timing_rx_sat_counter.sv
// Saturating up-counter; a clear restarts the count and lets the current
// clock's increment land in the new interval.
module sat_counter
  import video_rx_pkg::*;
#(
  parameter int CNT_BITS = DEF_CNT_BITS
) (
  input  logic                clk,
  input  logic                resetn,
  input  logic                clr,
  input  logic                inc,
  output logic [CNT_BITS-1:0] value,
  output logic                sat
);

  assign sat = &value;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      value <= '0;
    end else if (clr) begin
      value <= CNT_BITS'(inc);
    end else if (inc && !sat) begin
      value <= value + CNT_BITS'(1);
    end
  end

endmodule

// File: rtl/video_timing_rx.sv
// Measures line/frame timing and a per-frame colour checksum of an incoming
// DE/HSYNC/VSYNC video stream and reports lock on repeated identical frames.
module video_timing_rx
  import video_rx_pkg::*;
#(
  parameter int CNT_BITS    = DEF_CNT_BITS,
  parameter int COLOR_BITS  = 36,
  parameter int SUM_BITS    = DEF_SUM_BITS,
  parameter int LOCK_FRAMES = DEF_LOCK_FRAMES
) (
  input  logic                  clk,
  input  logic                  resetn,
  input  logic                  video_de,
  input  logic                  video_hsyncn,
  input  logic                  video_vsyncn,
  input  logic [COLOR_BITS-1:0] video_color,
  output logic [CNT_BITS-1:0]   h_total,
  output logic [CNT_BITS-1:0]   h_active,
  output logic [CNT_BITS-1:0]   h_sync,
  output logic [CNT_BITS-1:0]   v_total,
  output logic [CNT_BITS-1:0]   v_active,
  output logic [CNT_BITS-1:0]   v_sync,
  output logic [SUM_BITS-1:0]   frame_sum,
  output logic                  meas_valid,
  output logic                  locked,
  output logic                  overflow,
  output logic [15:0]           frame_count
);

  localparam int ACC_BITS = (SUM_BITS > COLOR_BITS) ? SUM_BITS : COLOR_BITS;
  localparam int MC_BITS  = $clog2(LOCK_FRAMES + 1);

  typedef logic [NUM_TIMING-1:0][CNT_BITS-1:0] timing_t;

  function automatic logic [CNT_BITS-1:0] sat_inc(input logic [CNT_BITS-1:0] v,
                                                  input logic en);
    return (en && !(&v)) ? v + CNT_BITS'(1) : v;
  endfunction

  logic                  r_de, r_hsyncn, r_vsyncn, p_hsyncn, p_vsyncn;
  logic [COLOR_BITS-1:0] r_color;
  logic                  line_start, frame_start, line_de;
  logic [CNT_BITS-1:0]   hcnt, decnt, hscnt, vcnt, vacnt, vscnt;
  logic [5:0]            sat;
  logic [CNT_BITS-1:0]   lt_total, lt_active, lt_sync;
  timing_t               meas_nxt, pub;
  logic [SUM_BITS-1:0]   sum_acc, sum_nxt;
  logic [ACC_BITS-1:0]   sum_wide;
  logic                  ovf, ovf_now, publish, match;
  logic [MC_BITS-1:0]    matchcnt, mc_nxt;
  rx_state_t             state, state_nxt;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_de     <= 1'b0;
      r_hsyncn <= 1'b0;
      r_vsyncn <= 1'b0;
      p_hsyncn <= 1'b0;
      p_vsyncn <= 1'b0;
      r_color  <= '0;
    end else begin
      r_de     <= video_de;
      r_hsyncn <= video_hsyncn;
      r_vsyncn <= video_vsyncn;
      p_hsyncn <= r_hsyncn;
      p_vsyncn <= r_vsyncn;
      r_color  <= video_color;
    end
  end

  assign line_start  = !r_hsyncn && p_hsyncn;
  assign frame_start = !r_vsyncn && p_vsyncn;
  assign line_de     = |decnt;

  // Frame counters mask the coincident line start: it closes into the ending frame.
  sat_counter #(.CNT_BITS(CNT_BITS)) u_hcnt (.clk(clk), .resetn(resetn),
    .clr(line_start), .inc(!line_start), .value(hcnt), .sat(sat[0]));
  sat_counter #(.CNT_BITS(CNT_BITS)) u_decnt (.clk(clk), .resetn(resetn),
    .clr(line_start), .inc(r_de), .value(decnt), .sat(sat[1]));
  sat_counter #(.CNT_BITS(CNT_BITS)) u_hscnt (.clk(clk), .resetn(resetn),
    .clr(line_start), .inc(!r_hsyncn), .value(hscnt), .sat(sat[2]));
  sat_counter #(.CNT_BITS(CNT_BITS)) u_vcnt (.clk(clk), .resetn(resetn),
    .clr(frame_start), .inc(line_start && !frame_start), .value(vcnt), .sat(sat[3]));
  sat_counter #(.CNT_BITS(CNT_BITS)) u_vacnt (.clk(clk), .resetn(resetn),
    .clr(frame_start), .inc(line_start && line_de && !frame_start),
    .value(vacnt), .sat(sat[4]));
  sat_counter #(.CNT_BITS(CNT_BITS)) u_vscnt (.clk(clk), .resetn(resetn),
    .clr(frame_start), .inc(line_start && !r_vsyncn && !frame_start),
    .value(vscnt), .sat(sat[5]));

  always_comb begin
    meas_nxt            = '0;
    meas_nxt[T_HTOTAL]  = line_start ? sat_inc(hcnt, 1'b1) : lt_total;
    meas_nxt[T_HACTIVE] = (line_start && line_de) ? decnt : lt_active;
    meas_nxt[T_HSYNC]   = line_start ? hscnt : lt_sync;
    meas_nxt[T_VTOTAL]  = sat_inc(vcnt, line_start);
    meas_nxt[T_VACTIVE] = sat_inc(vacnt, line_start && line_de);
    meas_nxt[T_VSYNC]   = sat_inc(vscnt, line_start && !r_vsyncn);
  end

  assign sum_wide = ACC_BITS'(sum_acc) + ACC_BITS'(r_color);
  assign sum_nxt  = r_de ? sum_wide[SUM_BITS-1:0] : sum_acc;
  assign ovf_now  = ovf || (|sat);

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      lt_total  <= '0;
      lt_active <= '0;
      lt_sync   <= '0;
      sum_acc   <= '0;
      ovf       <= 1'b0;
    end else begin
      lt_total  <= meas_nxt[T_HTOTAL];
      lt_active <= meas_nxt[T_HACTIVE];
      lt_sync   <= meas_nxt[T_HSYNC];
      sum_acc   <= frame_start ? '0 : sum_nxt;
      ovf       <= frame_start ? 1'b0 : ovf_now;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) state <= IDLE;
    else         state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    publish   = 1'b0;
    case (state)
      IDLE:    if (frame_start) state_nxt = ARMED;
      ARMED:   if (frame_start) begin
                 publish   = 1'b1;
                 state_nxt = RUN;
               end
      RUN:     publish = frame_start;
      default: state_nxt = IDLE;
    endcase
  end

  // The first publish after IDLE has no valid previous set to compare against.
  assign match  = (state == RUN) && (meas_nxt == pub) && !ovf_now;
  assign mc_nxt = !match ? '0 :
                  (matchcnt == MC_BITS'(LOCK_FRAMES)) ? matchcnt : matchcnt + MC_BITS'(1);

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      pub         <= '0;
      frame_sum   <= '0;
      meas_valid  <= 1'b0;
      overflow    <= 1'b0;
      frame_count <= '0;
      matchcnt    <= '0;
    end else begin
      meas_valid <= publish;
      if (publish) begin
        pub         <= meas_nxt;
        frame_sum   <= sum_nxt;
        overflow    <= ovf_now;
        frame_count <= frame_count + 16'd1;
        matchcnt    <= mc_nxt;
      end
    end
  end

  assign locked   = (matchcnt == MC_BITS'(LOCK_FRAMES));
  assign h_total  = pub[T_HTOTAL];
  assign h_active = pub[T_HACTIVE];
  assign h_sync   = pub[T_HSYNC];
  assign v_total  = pub[T_VTOTAL];
  assign v_active = pub[T_VACTIVE];
  assign v_sync   = pub[T_VSYNC];

endmodule

// File: tb/tb_video_timing_rx.sv
// Self-checking bench for video_timing_rx: a table of generated frames with
// hand-computed publish values, plus a hand-written mid-frame reset sequence.
module tb_video_timing_rx;

  localparam int HACT = 12;
  localparam int HSW  = 3;
  localparam int VTOT = 10;
  localparam int VACT = 6;
  localparam int VSW  = 2;

  typedef struct {
    int          htot;
    logic [35:0] color;
    int          extra;
    int          stop_line;
    bit          pub;
    logic [11:0] e_htot;
    logic [31:0] e_sum;
    bit          e_locked;
    bit          e_ovf;
    logic [15:0] e_fc;
  } vec_t;

  logic        clk = 1'b0;
  logic        resetn;
  logic        video_de, video_hsyncn, video_vsyncn;
  logic [35:0] video_color;
  logic [11:0] h_total, h_active, h_sync, v_total, v_active, v_sync;
  logic [31:0] frame_sum;
  logic        meas_valid, locked, overflow;
  logic [15:0] frame_count;

  int   errors = 0;
  int   checks = 0;
  int   mv_count = 0;
  vec_t last;
  vec_t vecs[14];

  video_timing_rx dut (
    .clk(clk), .resetn(resetn),
    .video_de(video_de), .video_hsyncn(video_hsyncn), .video_vsyncn(video_vsyncn),
    .video_color(video_color),
    .h_total(h_total), .h_active(h_active), .h_sync(h_sync),
    .v_total(v_total), .v_active(v_active), .v_sync(v_sync),
    .frame_sum(frame_sum), .meas_valid(meas_valid), .locked(locked),
    .overflow(overflow), .frame_count(frame_count)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (meas_valid) mv_count++;

  function automatic vec_t mk(int htot, logic [35:0] color, int extra, int stop_line,
                              bit pub, logic [11:0] e_htot, logic [31:0] e_sum,
                              bit e_locked, bit e_ovf, logic [15:0] e_fc);
    vec_t v;
    v.htot = htot;  v.color = color;  v.extra = extra;  v.stop_line = stop_line;
    v.pub = pub;    v.e_htot = e_htot; v.e_sum = e_sum;  v.e_locked = e_locked;
    v.e_ovf = e_ovf; v.e_fc = e_fc;
    return v;
  endfunction

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic applyStimulus(input logic de, input logic hs, input logic vs, input logic [35:0] c);
    video_de     = de;
    video_hsyncn = hs;
    video_vsyncn = vs;
    video_color  = c;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      applyStimulus(1'b0, 1'b1, 1'b1, 36'h0);
    end
  endtask

  // Checks around the frame start at pixel 0 of line 0: old values hold at c=1,
  // the publish of the previous frame is visible at c=2 and gone at c=3.
  task automatic frameStartChecks(input vec_t f, input int c);
    if (c == 1) begin
      checkOutput("hold_locked", locked, last.e_locked);
      checkOutput("hold_h_total", h_total, last.e_htot);
      checkOutput("hold_frame_count", frame_count, last.e_fc);
      checkOutput("early_meas_valid", meas_valid, 0);
    end
    if (c == 2) begin
      checkOutput("meas_valid", meas_valid, f.pub);
      if (f.pub) begin
        checkOutput("h_total", h_total, f.e_htot);
        checkOutput("h_active", h_active, HACT);
        checkOutput("h_sync", h_sync, HSW);
        checkOutput("v_total", v_total, VTOT);
        checkOutput("v_active", v_active, VACT);
        checkOutput("v_sync", v_sync, VSW);
        checkOutput("frame_sum", frame_sum, f.e_sum);
        checkOutput("locked", locked, f.e_locked);
        checkOutput("overflow", overflow, f.e_ovf);
        checkOutput("frame_count", frame_count, f.e_fc);
        last = f;
      end
    end
    if (c == 3 && f.pub) checkOutput("meas_valid_pulse", meas_valid, 0);
  endtask

  task automatic sendFrame(input vec_t f);
    logic de;
    for (int l = 0; l < VTOT && l != f.stop_line; l++) begin
      for (int c = 0; c < f.htot + ((l == VTOT - 1) ? f.extra : 0); c++) begin
        @(negedge clk);
        if (l == 0) frameStartChecks(f, c);
        de = (l >= VSW + 1) && (l < VSW + 1 + VACT) && (c >= HSW + 2) && (c < HSW + 2 + HACT);
        applyStimulus(de, c >= HSW, l >= VSW, de ? f.color : 36'h0);
      end
    end
  endtask

  initial begin
    int mv_before;
    last = mk(0, 36'h0, 0, -1, 1'b0, 12'd0, 32'd0, 1'b0, 1'b0, 16'd0);

    vecs[0]  = mk(20, 36'h1, 0,    -1, 1'b0, 12'd0,    32'd0,        1'b0, 1'b0, 16'd0);
    vecs[1]  = mk(20, 36'h1, 0,    -1, 1'b1, 12'd20,   32'd72,       1'b0, 1'b0, 16'd1);
    vecs[2]  = mk(20, 36'h1, 0,    -1, 1'b1, 12'd20,   32'd72,       1'b0, 1'b0, 16'd2);
    vecs[3]  = mk(21, 36'h1, 0,    -1, 1'b1, 12'd20,   32'd72,       1'b1, 1'b0, 16'd3);
    vecs[4]  = mk(21, 36'h1, 0,    -1, 1'b1, 12'd21,   32'd72,       1'b0, 1'b0, 16'd4);
    vecs[5]  = mk(21, 36'h1, 0,    -1, 1'b1, 12'd21,   32'd72,       1'b0, 1'b0, 16'd5);
    vecs[6]  = mk(21, 36'h1, 5000, -1, 1'b1, 12'd21,   32'd72,       1'b1, 1'b0, 16'd6);
    vecs[7]  = mk(21, 36'h1, 0,    -1, 1'b1, 12'd4095, 32'd72,       1'b0, 1'b1, 16'd7);
    vecs[8]  = mk(21, 36'h1, 0,    -1, 1'b1, 12'd21,   32'd72,       1'b0, 1'b0, 16'd8);
    vecs[9]  = mk(21, 36'hFFFFFFFFF, 0, -1, 1'b1, 12'd21, 32'd72,    1'b0, 1'b0, 16'd9);
    vecs[10] = mk(21, 36'h1, 0,    5,  1'b1, 12'd21,   32'hFFFFFFB8, 1'b1, 1'b0, 16'd10);
    vecs[11] = mk(21, 36'h1, 0,    -1, 1'b0, 12'd0,    32'd0,        1'b0, 1'b0, 16'd0);
    vecs[12] = mk(21, 36'h1, 0,    -1, 1'b1, 12'd21,   32'd72,       1'b0, 1'b0, 16'd1);
    vecs[13] = mk(21, 36'h1, 0,    -1, 1'b1, 12'd21,   32'd72,       1'b0, 1'b0, 16'd2);

    resetn = 1'b0;
    applyStimulus(1'b0, 1'b1, 1'b1, 36'h0);
    idle(3);
    checkOutput("reset_frame_count", frame_count, 0);
    checkOutput("reset_h_total", h_total, 0);
    checkOutput("reset_meas_valid", meas_valid, 0);
    @(negedge clk);
    resetn = 1'b1;
    idle(5);

    for (int i = 0; i <= 10; i++) sendFrame(vecs[i]);

    // Asynchronous reset in the middle of a frame clears outputs without a clock.
    @(negedge clk);
    #2 resetn = 1'b0;
    #1;
    checkOutput("midreset_h_total", h_total, 0);
    checkOutput("midreset_h_active", h_active, 0);
    checkOutput("midreset_h_sync", h_sync, 0);
    checkOutput("midreset_v_total", v_total, 0);
    checkOutput("midreset_v_active", v_active, 0);
    checkOutput("midreset_v_sync", v_sync, 0);
    checkOutput("midreset_frame_sum", frame_sum, 0);
    checkOutput("midreset_meas_valid", meas_valid, 0);
    checkOutput("midreset_locked", locked, 0);
    checkOutput("midreset_overflow", overflow, 0);
    checkOutput("midreset_frame_count", frame_count, 0);
    idle(3);
    @(negedge clk);
    resetn = 1'b1;
    idle(5);
    last = mk(0, 36'h0, 0, -1, 1'b0, 12'd0, 32'd0, 1'b0, 1'b0, 16'd0);

    mv_before = mv_count;
    sendFrame(vecs[11]);
    checkOutput("no_valid_after_reset", mv_count, mv_before);
    sendFrame(vecs[12]);
    sendFrame(vecs[13]);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/video_timing_rx.md
Name: video_timing_rx

Overview:
- Receive-side counterpart of the SoC video output port. Consumes de / active-low hsync / active-low vsync / 36-bit colour.
- Measures line and frame timing, accumulates a per-frame pixel checksum and reports lock once consecutive frames measure identically.
- Used as an on-chip loopback checker beside the display path and as the front end of a future frame-capture block.

Parameters:
- CNT_BITS, 12, width of every timing counter and timing output.
- COLOR_BITS, 36, width of video_color.
- SUM_BITS, 32, width of the frame checksum.
- LOCK_FRAMES, 2, consecutive identical measurements required to assert locked.

Ports:
- clk  in  1  video pixel clock.
- resetn  in  1  asynchronous active-low reset.
- video_de  in  1  data enable.
- video_hsyncn  in  1  horizontal sync, active low.
- video_vsyncn  in  1  vertical sync, active low.
- video_color  in  COLOR_BITS  pixel colour.
- h_total  out  CNT_BITS  clocks per line.
- h_active  out  CNT_BITS  DE clocks in the last line containing DE.
- h_sync  out  CNT_BITS  hsyncn-low clocks in the last line.
- v_total  out  CNT_BITS  lines per frame.
- v_active  out  CNT_BITS  lines containing at least one DE clock.
- v_sync  out  CNT_BITS  line starts seen while vsyncn low.
- frame_sum  out  SUM_BITS  sum of video_color over DE clocks, mod 2^SUM_BITS.
- meas_valid  out  1  one-clock pulse when outputs update.
- locked  out  1  timing stable.
- overflow  out  1  last published frame saturated a counter.
- frame_count  out  16  published frames, wraps.

Behaviour:
- Reset (async assert, sync release): every output 0, all counters 0, state IDLE.
- Input stage: all inputs registered once (stage R), plus a previous-value copy of both syncs.
- Line start = R.hsyncn 0 with previous 1. Frame start = R.vsyncn 0 with previous 1.
- Line counters, per line:
  - hcnt counts every clock.
  - decnt counts DE clocks.
  - hscnt counts clocks with R.hsyncn low.
  - On line start: capture hcnt+1 as line total, plus decnt and hscnt, into line registers; restart all three counters.
  - The line counts toward v_active iff decnt>0.
- Frame counters: vcnt increments per line start; vacnt per closed line with DE; vscnt per line start with R.vsyncn low; sum accumulates R.color on R.de (zero-extended, wraps).
- A line start and a frame start in the same clock: the line closes first and counts into the ending frame; the new frame counters start at 0.
- All timing counters saturate at all-ones and set a sticky ovf flag for the current frame. The flag clears at frame start.
- FSM:
  - IDLE: discard data. On frame start, clear counters and go to ARMED. No publish.
  - ARMED: on frame start, publish and go to RUN.
  - RUN: on frame start, publish.
- Publish:
  - Outputs load from the frame and last-line registers the clock after frame-start detection, i.e. 2 clocks after vsyncn falls at the pin.
  - meas_valid is high for exactly that clock.
  - frame_count increments; overflow = ovf.
  - Checksum is not part of lock.
- Lock:
  - match = the six timing values equal the previously published set, and ovf = 0.
  - On a match, matchcnt increments, saturating at LOCK_FRAMES.
  - Otherwise matchcnt = 0 and locked drops in the publish clock.
  - locked = (matchcnt == LOCK_FRAMES) and drops immediately on mismatch.
  - The first publish after IDLE never matches.
- Outputs hold between publishes.
- resetn low mid-frame: immediate return to reset state; first publish needs two new frame starts.

Decomposition:
- Shared package video_rx_pkg: FSM state encoding (IDLE, ARMED, RUN), default CNT_BITS / SUM_BITS / LOCK_FRAMES, timing record layout (six CNT_BITS fields).
- One sub-module sat_counter (CNT_BITS, inc, clr, value, sat flag), instantiated for the six timing counters.

Test Plan:
- Mode h_total 20, h_active 12, h_sync 3, v_total 10, v_active 6, v_sync 2, colour constant 1, three frames:
  - first meas_valid 2 clocks after the second vsyncn fall;
  - values 20 / 12 / 3 / 10 / 6 / 2, frame_sum 72;
  - locked 0 at the first publish, 1 at the third.
- Locked, then one frame with h_total 21 -> locked drops in that publish clock, h_total=21; locked returns after 2 further matching frames of 21.
- vsyncn and hsyncn falling in the same clock -> the coincident line counts in the ending frame; v_total=10, not 9 or 11.
- hsync stuck high for 5000 clocks with CNT_BITS=12 -> h_total=4095, overflow=1, locked=0; next clean frame -> overflow=0.
- Colour 36'hFFFFFFFFF on every DE clock, 72 DE clocks -> frame_sum = (72*(2^36-1)) mod 2^32 = 32'hFFFFFFB8.
- resetn pulsed low mid-frame -> all outputs 0 at once; no meas_valid until the second subsequent vsyncn fall; frame_count restarts at 1.
